pixel_fuzzifier: RTL and testbench

Streaming fuzzifier for the OV7670 pixel path. It maps each 8-bit intensity sample onto three triangular membership degrees (low / mid / high), each on a 0..256 scale, and emits them as 10-bit values that the defuzzification stage consumes directly. The path is a two-stage valid/ready pipeline with frame/line sideband pass-through. It also keeps per-frame counts of which fuzzy set dominates each pixel, and publishes them at each start of frame.

---
 rtl/pixel_fuzzifier_pkg.sv | 25 ++
 rtl/pixel_fuzzifier_if.sv | 41 ++++
 rtl/pixel_fuzzifier_membership.sv | 55 +++++
 rtl/pixel_fuzzifier.sv | 203 ++++++++++++++++++++
 tb/tb_pixel_fuzzifier.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_fuzzifier_pkg.sv
// Shared constants and types for the pixel fuzzifier path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: membership full scale, mid breakpoint, widths, dominance-class
// and counter-FSM enums. The defuzzifier imports the same scale constant.
package pixel_fuzzifier_pkg;

    localparam int PIX_W     = 8;     // membership math assumes 8-bit samples
    localparam int M_W       = 10;    // membership width; full scale fits in 9 bits
    localparam int CNT_W_DEF = 19;    // covers 640x480 pixels per frame
    localparam int M_SCALE   = 256;   // membership full scale (partition of unity)
    localparam int M_MID     = 128;   // breakpoint between the two triangle halves

    typedef enum logic [1:0] {
        CLS_LO  = 2'd0,
        CLS_MID = 2'd1,
        CLS_HI  = 2'd2
    } dom_cls_t;

    typedef enum logic {
        ST_WAIT_SOF = 1'b0,
        ST_COUNT    = 1'b1
    } cnt_state_t;

endpackage

// File: rtl/pixel_fuzzifier_if.sv
// Stream + statistics bundle between the pixel source, the fuzzifier and
// the defuzzifier/statistics consumers.
// Latency/backpressure: n/a (wires only); valid/ready on both streams.
// Ports: in_* (sample stream in), out_* (membership stream out),
// stat_* (per-frame dominance counts). master = environment, slave = block.
interface pixel_fuzzifier_if #(
    parameter int PIX_W = pixel_fuzzifier_pkg::PIX_W,
    parameter int M_W   = pixel_fuzzifier_pkg::M_W,
    parameter int CNT_W = pixel_fuzzifier_pkg::CNT_W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pix;
    logic             in_sof;
    logic             in_eol;

    logic             out_valid;
    logic             out_ready;
    logic [M_W-1:0]   out_mmin;
    logic [M_W-1:0]   out_mmid;
    logic [M_W-1:0]   out_mmax;
    logic             out_sof;
    logic             out_eol;

    logic             stat_valid;
    logic [CNT_W-1:0] stat_lo;
    logic [CNT_W-1:0] stat_mid;
    logic [CNT_W-1:0] stat_hi;

    modport master (
        output in_valid, in_pix, in_sof, in_eol, out_ready,
        input  in_ready, out_valid, out_mmin, out_mmid, out_mmax,
               out_sof, out_eol, stat_valid, stat_lo, stat_mid, stat_hi
    );

    modport slave (
        input  in_valid, in_pix, in_sof, in_eol, out_ready,
        output in_ready, out_valid, out_mmin, out_mmid, out_mmax,
               out_sof, out_eol, stat_valid, stat_lo, stat_mid, stat_hi
    );
endinterface

// File: rtl/pixel_fuzzifier_membership.sv
// Triangular membership (low/mid/high) of one 8-bit sample plus dominance class.
// Latency: purely combinational.
// Backpressure: none (no state).
// Ports: x = sample, lt_mid/le_mid = x<128 / x<=128 (precomputed so the
// pipeline can register them a stage early), mmin/mmid/mmax = degrees on a
// 0..256 scale, cls = dominant set with ties resolved to mid.
module fuzz_membership
    import pixel_fuzzifier_pkg::*;
(
    input  logic [PIX_W-1:0] x,
    input  logic             lt_mid,
    input  logic             le_mid,
    output logic [M_W-1:0]   mmin,
    output logic [M_W-1:0]   mmid,
    output logic [M_W-1:0]   mmax,
    output dom_cls_t         cls
);

    logic [M_W-1:0] x2;

    // 2x never exceeds 510, so it always fits the membership width.
    assign x2 = M_W'({x, 1'b0});

    always_comb begin
        mmin = '0;
        mmid = '0;
        mmax = '0;
        cls  = CLS_MID;

        if (lt_mid) begin
            mmin = M_W'(M_SCALE) - x2;
        end

        // Rising edge of the mid triangle up to and including 128, falling after.
        if (le_mid) begin
            mmid = x2;
        end else begin
            mmid = M_W'(2 * M_SCALE) - x2;
        end

        if (!lt_mid) begin
            mmax = x2 - M_W'(M_SCALE);
        end

        // Strict compares: x=64 and x=192 tie with mid and fall into mid.
        if (mmin > mmid) begin
            cls = CLS_LO;
        end else if (mmax > mmid) begin
            cls = CLS_HI;
        end else begin
            cls = CLS_MID;
        end
    end

endmodule

// File: rtl/pixel_fuzzifier.sv
// Streaming pixel fuzzifier: sample -> three membership degrees, with
// frame/line sideband and per-frame dominance statistics.
// Latency: 2 cycles input handshake -> out_valid; 1 beat/cycle sustained.
// Backpressure: each stage loads when empty or when the next stage drains;
// in_ready is combinational from out_ready. Outputs hold while stalled.
// Ports: clk, reset (sync, active-high), bus (slave side of pixel_fuzzifier_if).
module pixel_fuzzifier
    import pixel_fuzzifier_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
)
(
    input  logic            clk,
    input  logic            reset,
    pixel_fuzzifier_if.slave bus
);

    // ---------------- pipeline state ----------------
    logic             s1_valid;
    logic             s1_ready;
    logic [PIX_W-1:0] s1_pix;
    logic             s1_sof;
    logic             s1_eol;
    logic             s1_lt_mid;
    logic             s1_le_mid;

    logic             s2_valid;
    logic             s2_ready;
    logic [M_W-1:0]   s2_mmin;
    logic [M_W-1:0]   s2_mmid;
    logic [M_W-1:0]   s2_mmax;
    logic             s2_sof;
    logic             s2_eol;
    dom_cls_t         s2_cls;

    logic [M_W-1:0]   m_min;
    logic [M_W-1:0]   m_mid;
    logic [M_W-1:0]   m_max;
    dom_cls_t         m_cls;

    logic             in_hs;
    logic             out_hs;

    // ---------------- statistics state ----------------
    cnt_state_t       state;
    cnt_state_t       state_nxt;
    logic             cnt_load;
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt_lo;
    logic [CNT_W-1:0] cnt_mid;
    logic [CNT_W-1:0] cnt_hi;
    logic [CNT_W-1:0] stat_lo_q;
    logic [CNT_W-1:0] stat_mid_q;
    logic [CNT_W-1:0] stat_hi_q;
    logic             stat_valid_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // ---------------- handshakes ----------------
    assign s2_ready     = !s2_valid || bus.out_ready;
    assign s1_ready     = !s1_valid || s2_ready;
    assign bus.in_ready = s1_ready;

    assign in_hs  = bus.in_valid && s1_ready;
    assign out_hs = s2_valid && bus.out_ready;

    // ---------------- stage 1: sample + compare flags ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_pix    <= '0;
            s1_sof    <= 1'b0;
            s1_eol    <= 1'b0;
            s1_lt_mid <= 1'b0;
            s1_le_mid <= 1'b0;
        end else begin
            if (s1_ready) begin
                s1_valid <= bus.in_valid;
            end
            if (in_hs) begin
                s1_pix    <= bus.in_pix;
                s1_sof    <= bus.in_sof;
                s1_eol    <= bus.in_eol;
                s1_lt_mid <= (bus.in_pix <  PIX_W'(M_MID));
                s1_le_mid <= (bus.in_pix <= PIX_W'(M_MID));
            end
        end
    end

    fuzz_membership u_membership (
        .x      (s1_pix),
        .lt_mid (s1_lt_mid),
        .le_mid (s1_le_mid),
        .mmin   (m_min),
        .mmid   (m_mid),
        .mmax   (m_max),
        .cls    (m_cls)
    );

    // ---------------- stage 2: memberships + sideband ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_mmin  <= '0;
            s2_mmid  <= '0;
            s2_mmax  <= '0;
            s2_sof   <= 1'b0;
            s2_eol   <= 1'b0;
            s2_cls   <= CLS_MID;
        end else begin
            if (s2_ready) begin
                s2_valid <= s1_valid;
            end
            if (s1_valid && s2_ready) begin
                s2_mmin <= m_min;
                s2_mmid <= m_mid;
                s2_mmax <= m_max;
                s2_sof  <= s1_sof;
                s2_eol  <= s1_eol;
                s2_cls  <= m_cls;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_mmin  = s2_mmin;
    assign bus.out_mmid  = s2_mmid;
    assign bus.out_mmax  = s2_mmax;
    assign bus.out_sof   = s2_sof;
    assign bus.out_eol   = s2_eol;

    // ---------------- counter FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_WAIT_SOF;
        end else begin
            state <= state_nxt;
        end
    end

    // Counting follows the output side so stalled beats are never counted
    // twice; a partial frame before the first sof is ignored.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            ST_WAIT_SOF: begin
                if (out_hs && s2_sof) begin
                    cnt_load  = 1'b1;
                    state_nxt = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (out_hs) begin
                    cnt_load = s2_sof;
                    cnt_inc  = !s2_sof;
                end
            end
            default: begin
                state_nxt = ST_WAIT_SOF;
            end
        endcase
    end

    // ---------------- counters + published stats ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_lo       <= '0;
            cnt_mid      <= '0;
            cnt_hi       <= '0;
            stat_lo_q    <= '0;
            stat_mid_q   <= '0;
            stat_hi_q    <= '0;
            stat_valid_q <= 1'b0;
        end else begin
            stat_valid_q <= cnt_load;
            if (cnt_load) begin
                // Publish the finished frame, then restart with the sof beat itself.
                stat_lo_q  <= cnt_lo;
                stat_mid_q <= cnt_mid;
                stat_hi_q  <= cnt_hi;
                cnt_lo     <= (s2_cls == CLS_LO)  ? CNT_W'(1) : '0;
                cnt_mid    <= (s2_cls == CLS_MID) ? CNT_W'(1) : '0;
                cnt_hi     <= (s2_cls == CLS_HI)  ? CNT_W'(1) : '0;
            end else if (cnt_inc) begin
                case (s2_cls)
                    CLS_LO:  cnt_lo  <= sat_inc(cnt_lo);
                    CLS_HI:  cnt_hi  <= sat_inc(cnt_hi);
                    default: cnt_mid <= sat_inc(cnt_mid);
                endcase
            end
        end
    end

    assign bus.stat_valid = stat_valid_q;
    assign bus.stat_lo    = stat_lo_q;
    assign bus.stat_mid   = stat_mid_q;
    assign bus.stat_hi    = stat_hi_q;

endmodule

// File: tb/tb_pixel_fuzzifier.sv
// Self-checking bench for pixel_fuzzifier: hand-computed vector table,
// full sweep, random backpressure, frame statistics, mid-stream reset and
// counter saturation on a narrow-counter instance.
module tb_pixel_fuzzifier;
    import pixel_fuzzifier_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pixel_fuzzifier_if                bus   ();
    pixel_fuzzifier_if #(.CNT_W(4))   bus_s ();

    pixel_fuzzifier dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pixel_fuzzifier #(.CNT_W(4)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    // Reference membership block, checked against the hand table below.
    logic [7:0] ref_x;
    logic [9:0] ref_min, ref_mid, ref_max;
    dom_cls_t   ref_cls;
    fuzz_membership u_ref (
        .x      (ref_x),
        .lt_mid (ref_x <  8'd128),
        .le_mid (ref_x <= 8'd128),
        .mmin   (ref_min),
        .mmid   (ref_mid),
        .mmax   (ref_max),
        .cls    (ref_cls)
    );

    typedef struct {
        logic [7:0] x;
        int         mmin;
        int         mmid;
        int         mmax;
        dom_cls_t   cls;
    } vec_t;

    typedef struct {
        int   mmin;
        int   mmid;
        int   mmax;
        logic sof;
        logic eol;
        int   cyc;
    } exp_t;

    vec_t vecs[12];
    exp_t q[$];
    exp_t mon_e;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int pulses   = 0;
    int s_pulses = 0;
    bit lat_chk  = 1'b0;
    bit rand_on  = 1'b0;

    logic       hold_vld = 1'b0;
    logic [9:0] h_min, h_mid, h_max;
    logic       h_sof, h_eol;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [7:0] x, input logic sof, input logic eol);
        exp_t e;
        int   xi;
        xi     = int'(x);
        e.mmin = (xi < 128)  ? 256 - 2 * xi : 0;
        e.mmid = (xi <= 128) ? 2 * xi : 2 * (256 - xi);
        e.mmax = (xi >= 128) ? 2 * (xi - 128) : 0;
        e.sof  = sof;
        e.eol  = eol;
        e.cyc  = 0;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] x, input exp_t e);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_pix   = x;
        bus.in_sof   = e.sof;
        bus.in_eol   = e.eol;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.cyc = cyc;
                q.push_back(e);
                done = 1'b1;
            end else begin
                n++;
                if (n > 200) begin
                    chk("send_timeout", 0, 1);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_px(input logic [7:0] x, input logic sof, input logic eol);
        send(x, model(x, sof, eol));
    endtask

    task automatic wait_pulse(input string name, input int target);
        int n;
        n = 0;
        while (pulses < target && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk(name, pulses, target);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: scoreboard compare on handshakes, stability while stalled.
    always @(negedge clk) begin
        if (bus.stat_valid)   pulses++;
        if (bus_s.stat_valid) s_pulses++;
        if (reset) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                chk("stall_valid", int'(bus.out_valid), 1);
                chk("stall_mmin",  int'(bus.out_mmin), int'(h_min));
                chk("stall_mmid",  int'(bus.out_mmid), int'(h_mid));
                chk("stall_mmax",  int'(bus.out_mmax), int'(h_max));
                chk("stall_sb",    int'({bus.out_sof, bus.out_eol}), int'({h_sof, h_eol}));
            end
            hold_vld = bus.out_valid && !bus.out_ready;
            h_min = bus.out_mmin;
            h_mid = bus.out_mmid;
            h_max = bus.out_mmax;
            h_sof = bus.out_sof;
            h_eol = bus.out_eol;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    chk("out_mmin", int'(bus.out_mmin), mon_e.mmin);
                    chk("out_mmid", int'(bus.out_mmid), mon_e.mmid);
                    chk("out_mmax", int'(bus.out_mmax), mon_e.mmax);
                    chk("out_sof",  int'(bus.out_sof),  int'(mon_e.sof));
                    chk("out_eol",  int'(bus.out_eol),  int'(mon_e.eol));
                    chk("out_sum",  int'(bus.out_mmin) + int'(bus.out_mmid) + int'(bus.out_mmax), 256);
                    if (lat_chk) chk("latency", cyc - mon_e.cyc, 2);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int p1;
        int n;

        vecs[0]  = '{8'd0,   256,   0,   0, CLS_LO};
        vecs[1]  = '{8'd1,   254,   2,   0, CLS_LO};
        vecs[2]  = '{8'd63,  130, 126,   0, CLS_LO};
        vecs[3]  = '{8'd64,  128, 128,   0, CLS_MID};
        vecs[4]  = '{8'd65,  126, 130,   0, CLS_MID};
        vecs[5]  = '{8'd127,   2, 254,   0, CLS_MID};
        vecs[6]  = '{8'd128,   0, 256,   0, CLS_MID};
        vecs[7]  = '{8'd129,   0, 254,   2, CLS_MID};
        vecs[8]  = '{8'd191,   0, 130, 126, CLS_MID};
        vecs[9]  = '{8'd192,   0, 128, 128, CLS_MID};
        vecs[10] = '{8'd193,   0, 126, 130, CLS_HI};
        vecs[11] = '{8'd255,   0,   2, 254, CLS_HI};

        reset         = 1'b1;
        ref_x         = 8'd0;
        bus.in_valid  = 1'b0;
        bus.in_pix    = 8'd0;
        bus.in_sof    = 1'b0;
        bus.in_eol    = 1'b0;
        bus.out_ready = 1'b1;
        bus_s.in_valid  = 1'b0;
        bus_s.in_pix    = 8'd0;
        bus_s.in_sof    = 1'b0;
        bus_s.in_eol    = 1'b0;
        bus_s.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // ---- reset state ----
        @(negedge clk);
        chk("rst_out_valid",  int'(bus.out_valid), 0);
        chk("rst_stat_valid", int'(bus.stat_valid), 0);
        chk("rst_in_ready",   int'(bus.in_ready), 1);
        chk("rst_mem",        int'(bus.out_mmin) + int'(bus.out_mmid) + int'(bus.out_mmax), 0);
        chk("rst_sideband",   int'({bus.out_sof, bus.out_eol}), 0);
        chk("rst_stats",      int'(bus.stat_lo) + int'(bus.stat_mid) + int'(bus.stat_hi), 0);

        // ---- reference block vs hand table ----
        for (int i = 0; i < 12; i++) begin
            ref_x = vecs[i].x;
            #1;
            chk("ref_mmin", int'(ref_min), vecs[i].mmin);
            chk("ref_mmid", int'(ref_mid), vecs[i].mmid);
            chk("ref_mmax", int'(ref_max), vecs[i].mmax);
            chk("ref_cls",  int'(ref_cls), int'(vecs[i].cls));
        end

        // ---- hand table through the pipeline, back-to-back ----
        @(posedge clk);
        #1;
        lat_chk = 1'b1;
        for (int i = 0; i < 12; i++) begin
            exp_t e;
            e = '{vecs[i].mmin, vecs[i].mmid, vecs[i].mmax, 1'b0, 1'b0, 0};
            send(vecs[i].x, e);
        end
        drain();

        // ---- full sweep with out_ready held high ----
        for (int x = 0; x < 256; x++) begin
            send_px(8'(x), 1'b0, (x % 16) == 15);
        end
        drain();
        lat_chk = 1'b0;

        // ---- random backpressure, gaps with junk on in_pix ----
        rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [7:0] x;
                    n = $urandom_range(0, 2);
                    repeat (n) begin
                        bus.in_pix = 8'($urandom);
                        @(posedge clk);
                        #1;
                    end
                    x = 8'($urandom);
                    send_px(x, ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
                end
                rand_on = 1'b0;
            end
        join
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain();

        // ---- frame statistics: A = {10,64,100,192,200}, then sof of B ----
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        q.delete();
        p0 = pulses;
        send_px(8'd10,  1'b1, 1'b0);
        send_px(8'd64,  1'b0, 1'b0);
        send_px(8'd100, 1'b0, 1'b0);
        send_px(8'd192, 1'b0, 1'b0);
        send_px(8'd200, 1'b0, 1'b1);
        wait_pulse("first_sof_pulse", p0 + 1);
        chk("first_sof_lo",  int'(bus.stat_lo),  0);
        chk("first_sof_mid", int'(bus.stat_mid), 0);
        chk("first_sof_hi",  int'(bus.stat_hi),  0);
        @(posedge clk);
        #1;
        send_px(8'd0, 1'b1, 1'b0);
        wait_pulse("frame_b_pulse", p0 + 2);
        chk("frame_a_lo",  int'(bus.stat_lo),  1);
        chk("frame_a_mid", int'(bus.stat_mid), 3);
        chk("frame_a_hi",  int'(bus.stat_hi),  1);
        repeat (5) @(negedge clk);
        chk("single_pulse", pulses, p0 + 2);
        chk("stat_hold_mid", int'(bus.stat_mid), 3);

        // ---- reset with two beats in flight ----
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send_px(8'd150, 1'b0, 1'b0);
        send_px(8'd160, 1'b0, 1'b0);
        @(negedge clk);
        chk("inflight_stall", int'({bus.out_valid, bus.in_ready}), 2);
        p1 = pulses;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        q.delete();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("rst_flush_valid", int'(bus.out_valid), 0);
        chk("rst_flush_ready", int'(bus.in_ready), 1);
        chk("rst_no_pulse",    pulses, p1);
        @(posedge clk);
        #1;
        send_px(8'd0, 1'b1, 1'b0);
        wait_pulse("post_rst_pulse", p1 + 1);
        chk("post_rst_lo",  int'(bus.stat_lo),  0);
        chk("post_rst_mid", int'(bus.stat_mid), 0);
        chk("post_rst_hi",  int'(bus.stat_hi),  0);
        @(posedge clk);
        #1;
        send_px(8'd200, 1'b0, 1'b0);
        send_px(8'd200, 1'b0, 1'b1);
        send_px(8'd128, 1'b1, 1'b0);
        wait_pulse("frame_d_pulse", p1 + 2);
        chk("frame_d_lo",  int'(bus.stat_lo),  1);
        chk("frame_d_mid", int'(bus.stat_mid), 0);
        chk("frame_d_hi",  int'(bus.stat_hi),  2);
        drain();

        // ---- saturation on the 4-bit counter instance: 20 low pixels ----
        for (int i = 0; i < 20; i++) begin
            bus_s.in_valid = 1'b1;
            bus_s.in_pix   = 8'd5;
            bus_s.in_sof   = (i == 0);
            @(negedge clk);
            chk("sat_in_ready", int'(bus_s.in_ready), 1);
            @(posedge clk);
            #1;
        end
        bus_s.in_pix = 8'd128;
        bus_s.in_sof = 1'b1;
        @(posedge clk);
        #1;
        bus_s.in_valid = 1'b0;
        bus_s.in_sof   = 1'b0;
        n = 0;
        while (s_pulses < 2 && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("sat_pulses", s_pulses, 2);
        chk("sat_lo",  int'(bus_s.stat_lo),  15);
        chk("sat_mid", int'(bus_s.stat_mid), 0);
        chk("sat_hi",  int'(bus_s.stat_hi),  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
